bip_prog_loader: RTL and testbench

Program loader for the BIP processor: receives a byte stream from the UART receiver, packs byte pairs into 16-bit instruction words, and writes them sequentially into program memory from address 0. Loading ends on the HALT word or when memory is full. The block then raises `o_prog_ready`, which drives the control unit's `i_valid` so the CPU starts fetching. It is the writer side of the program-memory interface that the control unit reads through `o_addr`/`i_instruction`.

---
 rtl/bip_prog_loader_if.sv | 24 ++
 rtl/bip_prog_loader.sv | 63 ++++++
 tb/tb_bip_prog_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bip_prog_loader_if.sv
// bip_prog_loader_if: byte-stream input, program-memory write port and load status of the loader
interface bip_prog_loader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = 16,
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  restart;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  prog_ready;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   count;
  modport master (
    output rx_data, rx_valid, restart,
    input  wr_en, wr_addr, wr_data, prog_ready, overflow, count
  );
  modport slave (
    input  rx_data, rx_valid, restart,
    output wr_en, wr_addr, wr_data, prog_ready, overflow, count
  );
endinterface

// File: rtl/bip_prog_loader.sv
// bip_prog_loader: packs big-endian byte pairs into instruction words and writes them from address 0 until HALT or full
module bip_prog_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD = '0
) (
  input logic i_clk,
  input logic i_reset,
  bip_prog_loader_if.slave bus
);
  typedef enum logic [1:0] {S_HIGH, S_LOW, S_DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BYTE_WIDTH-1:0] high;
  logic [WORD_WIDTH-1:0] word;
  logic take_hi, take_lo, last, full;
  // Byte acceptance and next state; restart wins over a same-cycle byte
  always_comb begin
    word = {high, bus.rx_data};
    take_hi = !bus.restart && bus.rx_valid && state == S_HIGH;
    take_lo = !bus.restart && bus.rx_valid && state == S_LOW;
    last = word == HALT_WORD || addr == '1;
    state_nx = bus.restart ? S_HIGH : take_hi ? S_LOW : take_lo ? (last ? S_DONE : S_HIGH) : state;
  end
  // State register
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) state <= S_HIGH;
    else state <= state_nx;
  // Write port, address/count and status; ready follows the final strobe by one cycle so the write lands first
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      addr <= '0;
      high <= '0;
      full <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.count <= '0;
      bus.prog_ready <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.wr_en <= take_lo;
      if (bus.restart) begin
        addr <= '0;
        full <= 1'b0;
        bus.count <= '0;
        bus.prog_ready <= 1'b0;
        bus.overflow <= 1'b0;
      end else begin
        if (take_hi) high <= bus.rx_data;
        if (take_lo) begin
          bus.wr_addr <= addr;
          bus.wr_data <= word;
          addr <= addr + 1'b1;
          bus.count <= bus.count + 1'b1;
          full <= word != HALT_WORD && addr == '1;
        end
        bus.prog_ready <= state == S_DONE;
        bus.overflow <= state == S_DONE && full;
      end
    end
endmodule

// File: tb/tb_bip_prog_loader.sv
// tb_bip_prog_loader: byte-level model of the loader checked every cycle, plus literal load scenarios
module tb_bip_prog_loader;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int nb, nw;
  logic [7:0] hi;
  logic [15:0] w;
  logic done, ovf;
  logic m_wr_en, m_ready, m_ovf;
  logic [31:0] m_addr, m_data;

  always #5 i_clk = ~i_clk;

  bip_prog_loader_if bus ();

  bip_prog_loader dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus.slave));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every second accepted byte completes a word; loading stops on HALT (0) or at 2048 words
  always @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      nb = 0; nw = 0; hi = 0; done = 0; ovf = 0;
      m_wr_en = 0; m_ready = 0; m_ovf = 0; m_addr = 0; m_data = 0;
    end else begin
      m_wr_en = 0;
      if (bus.restart) begin
        nb = 0; nw = 0; done = 0; ovf = 0; m_ready = 0; m_ovf = 0;
      end else begin
        m_ready = done;
        m_ovf = done && ovf;
        if (bus.rx_valid && !done) begin
          if (nb % 2 == 0) hi = bus.rx_data;
          else begin
            w = {hi, bus.rx_data};
            m_wr_en = 1;
            m_addr = nw;
            m_data = {16'h0, w};
            nw++;
            if (w == 16'h0000 || nw == 2048) begin
              done = 1;
              ovf = w != 16'h0000;
            end
          end
          nb++;
        end
      end
    end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge i_clk)
    if (i_reset) begin
      check("wr_en", {31'b0, bus.wr_en}, {31'b0, m_wr_en});
      if (m_wr_en) begin
        check("wr_addr", {21'b0, bus.wr_addr}, m_addr);
        check("wr_data", {16'b0, bus.wr_data}, m_data);
      end
      check("count", {20'b0, bus.count}, nw);
      check("prog_ready", {31'b0, bus.prog_ready}, {31'b0, m_ready});
      check("overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
      if (bus.wr_en) begin
        log_a.push_back({21'b0, bus.wr_addr});
        log_d.push_back({16'b0, bus.wr_data});
      end
    end

  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(negedge i_clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic restart_pulse();
    bus.restart = 1'b1;
    @(negedge i_clk);
    bus.restart = 1'b0;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_wr_en"}, {31'b0, bus.wr_en}, 0);
    check({nm, "_wr_addr"}, {21'b0, bus.wr_addr}, 0);
    check({nm, "_wr_data"}, {16'b0, bus.wr_data}, 0);
    check({nm, "_count"}, {20'b0, bus.count}, 0);
    check({nm, "_ready"}, {31'b0, bus.prog_ready}, 0);
    check({nm, "_overflow"}, {31'b0, bus.overflow}, 0);
  endtask

  task automatic check_log(input string nm, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < log_a.size()) begin
      check({nm, "_addr"}, log_a[idx], a);
      check({nm, "_data"}, log_d[idx], d);
    end else check({nm, "_missing"}, idx, log_a.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.restart = 1'b0;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_reset = 1'b1;
    // Basic load with gaps between bytes
    put(8'h08); put(8'h05); idle(1); put(8'h18); put(8'h03); idle(2); put(8'h00); put(8'h00); idle(3);
    check("basic_nwrites", log_a.size(), 3);
    check_log("basic_w0", 0, 0, 32'h0805);
    check_log("basic_w1", 1, 1, 32'h1803);
    check_log("basic_w2", 2, 2, 32'h0000);
    check("basic_ready", {31'b0, bus.prog_ready}, 1);
    check("basic_count", {20'b0, bus.count}, 3);
    check("basic_overflow", {31'b0, bus.overflow}, 0);
    // Restart after done, then back-to-back load from address 0
    restart_pulse();
    check("rst_done_ready", {31'b0, bus.prog_ready}, 0);
    check("rst_done_count", {20'b0, bus.count}, 0);
    clear_log();
    put(8'h12); put(8'h34); put(8'h56); put(8'h78); put(8'h00); put(8'h00); idle(3);
    check("b2b_nwrites", log_a.size(), 3);
    check_log("b2b_w0", 0, 0, 32'h1234);
    check_log("b2b_w1", 1, 1, 32'h5678);
    check_log("b2b_w2", 2, 2, 32'h0000);
    check("b2b_ready", {31'b0, bus.prog_ready}, 1);
    // Restart in the same cycle as the low byte drops the half word
    restart_pulse();
    clear_log();
    put(8'hAB);
    bus.restart = 1'b1;
    put(8'hCD);
    bus.restart = 1'b0;
    idle(2);
    check("midword_nwrites", log_a.size(), 0);
    check("midword_count", {20'b0, bus.count}, 0);
    put(8'h00); put(8'h00); idle(3);
    check("midword_nwrites2", log_a.size(), 1);
    check_log("midword_w0", 0, 0, 32'h0000);
    check("midword_count2", {20'b0, bus.count}, 1);
    check("midword_ready", {31'b0, bus.prog_ready}, 1);
    // Asynchronous reset between high and low byte of the second word
    restart_pulse();
    clear_log();
    put(8'h11); put(8'h22); put(8'h33); idle(1);
    check("async_pre_count", {20'b0, bus.count}, 1);
    #2 i_reset = 1'b0;
    #1 check_all_zero("async");
    @(negedge i_clk);
    i_reset = 1'b1;
    clear_log();
    put(8'h00); put(8'h00); idle(3);
    check("async_nwrites", log_a.size(), 1);
    check_log("async_w0", 0, 0, 32'h0000);
    check("async_count", {20'b0, bus.count}, 1);
    // Fill all of memory without a HALT word
    restart_pulse();
    clear_log();
    for (int i = 0; i < 2048; i++) begin
      put(8'h08); put(8'h01);
    end
    idle(3);
    check("ovf_nwrites", log_a.size(), 2048);
    check_log("ovf_last", 2047, 2047, 32'h0801);
    check("ovf_ready", {31'b0, bus.prog_ready}, 1);
    check("ovf_overflow", {31'b0, bus.overflow}, 1);
    check("ovf_count", {20'b0, bus.count}, 2048);
    put(8'h00); put(8'h00); put(8'h05); put(8'h06); idle(2);
    check("ovf_no_more_writes", log_a.size(), 2048);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
